fiber_pe_arbiter: RTL and testbench
===================================

# fiber_pe_arbiter

Shares the single PE-side request port of the `fiber` cache between NUM_PE processing elements. It grants requests round-robin and forwards the winner's type, address and data to the cache's `i_request_type`/`i_addr`/`i_data`/`i_type_valid`/`o_type_ready` handshake. It routes returned data (`o_pe_data_o` path) back to the originating PE, in order, through an ID FIFO. It sits between the PE crossbar and one `fiber` instance.

## Interface
Parameters:
- NUM_PE, 4: number of requesters (≥2)
- DATA_WIDTH, 16: data word width
- ADDR_WIDTH, 64: address width
- RSP_DEPTH, 4: max outstanding data-returning requests (power of two)

Ports:
- i_clk  in  1  clock; all logic on rising edge
- i_reset  in  1  asynchronous, active-high reset
- i_pe_request_type  in  4*NUM_PE  one-hot FETCH=0001, READ=0010, WRITE=0100, CONSUME=1000; PE k at [4k+3:4k]
- i_pe_addr  in  ADDR_WIDTH*NUM_PE  request address per PE
- i_pe_data  in  DATA_WIDTH*NUM_PE  write data per PE
- i_pe_valid  in  NUM_PE  request valid per PE
- o_pe_ready  out  NUM_PE  one-cycle accept pulse per PE
- o_pe_rsp_data  out  DATA_WIDTH  response data, broadcast to all PEs
- o_pe_rsp_valid  out  NUM_PE  response valid, one-hot to the owner
- i_pe_rsp_ready  in  NUM_PE  response ready per PE
- o_request_type  out  4  to cache `i_request_type`
- o_addr  out  ADDR_WIDTH  to cache `i_addr`
- o_data  out  DATA_WIDTH  to cache `i_data`
- o_type_valid  out  1  to cache `i_type_valid`
- i_type_ready  in  1  from cache `o_type_ready`
- i_rsp_data  in  DATA_WIDTH  from cache `o_pe_data_o`
- i_rsp_valid  in  1  from cache `o_pe_data_o_valid`
- o_rsp_ready  out  1  to cache `i_pe_data_o_ready`
- o_err_illegal  out  1  one-cycle pulse: non-one-hot type dropped

## Operation
- FSM with two states: IDLE and ISSUE.
- Response-type requests are READ and CONSUME. FETCH and WRITE return nothing.
- Eligibility:
  - PE k is eligible when i_pe_valid[k]=1.
  - A response-type request from PE k is also gated by FIFO count < RSP_DEPTH.
- IDLE:
  - Pick the first eligible PE scanning from rr_ptr upward, with wrap-around.
  - Pulse o_pe_ready[w] for that cycle.
  - Latch type, addr and data into the output registers.
  - If the type is illegal (not exactly one bit set): pulse o_err_illegal, advance rr_ptr, stay in IDLE, forward nothing.
  - Otherwise:
    - If the type is response-type, push w into the ID FIFO in the same cycle (slot reserved at grant).
    - Go to ISSUE.
- ISSUE:
  - Hold o_type_valid=1 with the outputs stable.
  - On i_type_ready=1, drop o_type_valid, set rr_ptr=(w+1) mod NUM_PE, and go to IDLE.
- Response path (combinational from FIFO head h):
  - o_pe_rsp_data = i_rsp_data.
  - o_pe_rsp_valid = one-hot(h) when i_rsp_valid and FIFO non-empty; otherwise 0.
  - o_rsp_ready = FIFO non-empty & i_pe_rsp_ready[h].
  - Pop when i_rsp_valid & o_rsp_ready.
- A response arriving with an empty FIFO is not acknowledged; o_rsp_ready stays 0 and the cache stalls.
- Push and pop in the same cycle: count is unchanged and both take effect. Full-with-pop does not make a waiting request eligible that cycle.
- Reset mid-operation: the FSM goes to IDLE, the FIFO empties, rr_ptr returns to 0, and any request in ISSUE is abandoned. The PE must re-issue it.

## Timing
- Reset values:
  - o_pe_ready=0, o_type_valid=0, o_err_illegal=0.
  - o_request_type=0, o_addr=0, o_data=0.
  - rr_ptr=0, FIFO count=0.
  - o_pe_rsp_valid=0 and o_rsp_ready=0 (follow from the empty FIFO).
- Grant to o_type_valid: 1 cycle (registered).
- Best-case throughput: one request per 2 cycles.
- o_type_valid is held until the i_type_ready cycle.
- Response path latency: 0 cycles (combinational pass-through).
- Fairness: after PE w is served it has lowest priority, so no PE waits more than NUM_PE-1 grants.

## Structure
- Shared package `fiber_pkg`:
  - request-type constants FETCH_REQ, READ_REQ, WRITE_REQ, CONSUME_REQ
  - helper `is_rsp_type` (READ|CONSUME)
- One sub-module, `fiber_id_fifo`: synchronous FIFO of $clog2(NUM_PE)-bit IDs, RSP_DEPTH entries, push/pop/count/head, async active-high reset.
- Round-robin pick and FSM stay in the top module.

## Test plan
- Single WRITE from PE 2 (addr 0x00000000FFFFFFFF, data 0xFFFF), i_type_ready tied high:
  - o_pe_ready[2] pulses one cycle.
  - Next cycle o_type_valid=1 with o_request_type=0100 and matching addr/data.
  - FIFO stays empty.
- All four PEs issue WRITE continuously after reset: grant order 0,1,2,3,0,… with one grant every 2 cycles.
- PE 1 READ, then PE 3 READ; cache returns 0xAAAA then 0x5555:
  - o_pe_rsp_valid=0010 with data 0xAAAA, then 1000 with data 0x5555.
- Backpressure:
  - Hold i_type_ready=0 for 5 cycles: o_type_valid and outputs stay stable, with no new grants.
  - Hold i_pe_rsp_ready[1]=0: o_rsp_ready=0 until it rises.
- RSP_DEPTH=4 READs outstanding with no responses: a 5th READ is not granted, while a concurrent WRITE from another PE is granted. One response pop lets the READ be granted next cycle.
- Request type 0011: o_pe_ready pulses, o_err_illegal pulses, o_type_valid stays 0. Separately, assert i_reset while in ISSUE: all outputs return to reset values immediately.

Source files
------------

// File: rtl/fiber_pkg.sv
// -----------------------------------------------------------------------------
// fiber_pkg
// Shared definitions for the fiber cache request path: one-hot request-type
// encodings, the arbiter FSM state type and small request-type helpers.
// -----------------------------------------------------------------------------
package fiber_pkg;

  localparam logic [3:0] FETCH_REQ   = 4'b0001;
  localparam logic [3:0] READ_REQ    = 4'b0010;
  localparam logic [3:0] WRITE_REQ   = 4'b0100;
  localparam logic [3:0] CONSUME_REQ = 4'b1000;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } arb_state_t;

  // READ and CONSUME are the only request types the cache answers with data.
  function automatic logic is_rsp_type(input logic [3:0] t);
    return (t == READ_REQ) || (t == CONSUME_REQ);
  endfunction

  // A legal request type has exactly one bit set.
  function automatic logic is_onehot4(input logic [3:0] t);
    return (t != 4'b0000) && ((t & (t - 4'd1)) == 4'b0000);
  endfunction

endpackage

// File: rtl/fiber_id_fifo.sv
// -----------------------------------------------------------------------------
// fiber_id_fifo
// Synchronous FIFO of requester IDs. One entry is reserved per granted
// data-returning request; the head names the PE that owns the next response.
//
// Ports:
//   i_clk      clock, rising edge
//   i_reset    asynchronous active-high reset (empties the FIFO)
//   i_push     write i_push_id (ignored when full and not popping)
//   i_push_id  requester ID to enqueue
//   i_pop      remove the head entry (ignored when empty)
//   o_head     ID at the head of the FIFO (valid when o_count != 0)
//   o_count    number of stored entries, 0..DEPTH
// -----------------------------------------------------------------------------
module fiber_id_fifo #(
  parameter int ID_W  = 2,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_push,
  input  logic [ID_W-1:0]  i_push_id,
  input  logic             i_pop,
  output logic [ID_W-1:0]  o_head,
  output logic [CNT_W-1:0] o_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [ID_W-1:0]  r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_empty;
  logic w_full;
  logic w_do_push;
  logic w_do_pop;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CNT_W'(DEPTH));
  assign w_do_pop  = i_pop && !w_empty;
  // A full FIFO still accepts a push in the cycle it is popped.
  assign w_do_push = i_push && (!w_full || w_do_pop);

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // NOTE: the storage array has no reset; an entry is only read after it has
  // been written, and the pointers/count alone define what is valid.
  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_push_id;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_do_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/fiber_pe_arbiter.sv
// -----------------------------------------------------------------------------
// fiber_pe_arbiter
// Shares the single PE-side request port of one fiber cache between NUM_PE
// processing elements. Requests are granted round-robin and forwarded through
// a registered valid/ready handshake; returned data is steered back, in
// order, to the PE recorded in an ID FIFO at grant time.
//
// Ports:
//   i_clk, i_reset        clock / asynchronous active-high reset
//   i_pe_request_type     one-hot type per PE, PE k at [4k+3:4k]
//   i_pe_addr, i_pe_data  address / write data per PE
//   i_pe_valid            request valid per PE
//   o_pe_ready            one-cycle accept pulse to the granted PE
//   o_pe_rsp_data         response data, broadcast to all PEs
//   o_pe_rsp_valid        response valid, one-hot to the owning PE
//   i_pe_rsp_ready        response ready per PE
//   o_request_type, o_addr, o_data, o_type_valid / i_type_ready
//                         request handshake to the cache
//   i_rsp_data, i_rsp_valid / o_rsp_ready
//                         response handshake from the cache
//   o_err_illegal         one-cycle pulse when a non-one-hot request is dropped
// -----------------------------------------------------------------------------
module fiber_pe_arbiter
  import fiber_pkg::*;
#(
  parameter int NUM_PE     = 4,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 64,
  parameter int RSP_DEPTH  = 4
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic [4*NUM_PE-1:0]          i_pe_request_type,
  input  logic [ADDR_WIDTH*NUM_PE-1:0] i_pe_addr,
  input  logic [DATA_WIDTH*NUM_PE-1:0] i_pe_data,
  input  logic [NUM_PE-1:0]            i_pe_valid,
  output logic [NUM_PE-1:0]            o_pe_ready,
  output logic [DATA_WIDTH-1:0]        o_pe_rsp_data,
  output logic [NUM_PE-1:0]            o_pe_rsp_valid,
  input  logic [NUM_PE-1:0]            i_pe_rsp_ready,
  output logic [3:0]                   o_request_type,
  output logic [ADDR_WIDTH-1:0]        o_addr,
  output logic [DATA_WIDTH-1:0]        o_data,
  output logic                         o_type_valid,
  input  logic                         i_type_ready,
  input  logic [DATA_WIDTH-1:0]        i_rsp_data,
  input  logic                         i_rsp_valid,
  output logic                         o_rsp_ready,
  output logic                         o_err_illegal
);

  localparam int ID_W  = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
  localparam int CNT_W = $clog2(RSP_DEPTH + 1);

  arb_state_t r_state;
  arb_state_t w_next_state;

  logic [ID_W-1:0]       r_rr_ptr;
  logic [ID_W-1:0]       r_winner;
  logic [3:0]            r_type;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_data;

  logic [NUM_PE-1:0]     w_elig;
  logic                  w_grant_valid;
  logic [ID_W-1:0]       w_grant_id;
  logic [3:0]            w_sel_type;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [DATA_WIDTH-1:0] w_sel_data;
  logic                  w_sel_legal;
  logic                  w_grant_fire;

  logic [NUM_PE-1:0]     w_pe_ready;
  logic                  w_err;
  logic                  w_push;
  logic                  w_pop;
  logic [ID_W-1:0]       w_head;
  logic [CNT_W-1:0]      w_count;
  logic                  w_empty;
  logic                  w_full;
  logic [NUM_PE-1:0]     w_rsp_valid_vec;

  function automatic logic [ID_W-1:0] id_inc(input logic [ID_W-1:0] id);
    return (id == ID_W'(NUM_PE - 1)) ? '0 : id + 1'b1;
  endfunction

  assign w_empty = (w_count == '0);
  // Uses the registered count: a pop in this cycle does not free a slot
  // for a grant in the same cycle.
  assign w_full  = (w_count == CNT_W'(RSP_DEPTH));

  // A data-returning request is only eligible while a FIFO slot is free.
  always_comb begin
    for (int k = 0; k < NUM_PE; k++) begin
      w_elig[k] = i_pe_valid[k] &&
                  (!is_rsp_type(i_pe_request_type[4*k +: 4]) || !w_full);
    end
  end

  // Round-robin pick: first eligible PE at or after r_rr_ptr, wrapping.
  always_comb begin
    w_grant_valid = 1'b0;
    w_grant_id    = '0;
    for (int i = 0; i < NUM_PE; i++) begin
      if (!w_grant_valid && w_elig[(int'(r_rr_ptr) + i) % NUM_PE]) begin
        w_grant_valid = 1'b1;
        w_grant_id    = ID_W'((int'(r_rr_ptr) + i) % NUM_PE);
      end
    end
  end

  assign w_sel_type   = i_pe_request_type[4*int'(w_grant_id) +: 4];
  assign w_sel_addr   = i_pe_addr[ADDR_WIDTH*int'(w_grant_id) +: ADDR_WIDTH];
  assign w_sel_data   = i_pe_data[DATA_WIDTH*int'(w_grant_id) +: DATA_WIDTH];
  assign w_sel_legal  = is_onehot4(w_sel_type);
  assign w_grant_fire = (r_state == ST_IDLE) && w_grant_valid;

  // NOTE: every output of this block gets a default before the case so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    w_pe_ready   = '0;
    w_err        = 1'b0;
    w_push       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_grant_valid) begin
          w_pe_ready[w_grant_id] = 1'b1;
          if (!w_sel_legal) begin
            w_err = 1'b1;
          end else begin
            w_push       = is_rsp_type(w_sel_type);
            w_next_state = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        if (i_type_ready) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state  <= ST_IDLE;
      r_rr_ptr <= '0;
      r_winner <= '0;
      r_type   <= '0;
      r_addr   <= '0;
      r_data   <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_grant_fire) begin
        r_type   <= w_sel_type;
        r_addr   <= w_sel_addr;
        r_data   <= w_sel_data;
        r_winner <= w_grant_id;
        // A dropped illegal request still counts as a turn.
        if (!w_sel_legal) r_rr_ptr <= id_inc(w_grant_id);
      end
      if ((r_state == ST_ISSUE) && i_type_ready) begin
        r_rr_ptr <= id_inc(r_winner);
      end
    end
  end

  fiber_id_fifo #(
    .ID_W  (ID_W),
    .DEPTH (RSP_DEPTH),
    .CNT_W (CNT_W)
  ) u_id_fifo (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_push    (w_push),
    .i_push_id (w_grant_id),
    .i_pop     (w_pop),
    .o_head    (w_head),
    .o_count   (w_count)
  );

  // Response steering is combinational from the FIFO head.
  always_comb begin
    w_rsp_valid_vec = '0;
    if (i_rsp_valid && !w_empty) w_rsp_valid_vec[w_head] = 1'b1;
  end

  assign o_rsp_ready    = !w_empty && i_pe_rsp_ready[w_head];
  assign w_pop          = i_rsp_valid && o_rsp_ready;
  assign o_pe_rsp_valid = w_rsp_valid_vec;
  assign o_pe_rsp_data  = i_rsp_data;

  // Accept pulses are combinational in IDLE; masking with reset keeps them
  // low while reset is held even if PEs are still requesting.
  assign o_pe_ready     = w_pe_ready & {NUM_PE{~i_reset}};
  assign o_err_illegal  = w_err & ~i_reset;

  assign o_type_valid   = (r_state == ST_ISSUE);
  assign o_request_type = r_type;
  assign o_addr         = r_addr;
  assign o_data         = r_data;

endmodule

// File: tb/tb_fiber_pe_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fiber_pe_arbiter
// Directed self-checking bench for fiber_pe_arbiter (NUM_PE=4, DATA_WIDTH=16,
// ADDR_WIDTH=64, RSP_DEPTH=4). Inputs change 1 time unit after a rising edge
// and outputs are sampled 1-2 units after the edge.
// -----------------------------------------------------------------------------
module tb_fiber_pe_arbiter;

  localparam int NUM_PE = 4;
  localparam int DW     = 16;
  localparam int AW     = 64;
  localparam int DEPTH  = 4;

  localparam logic [3:0] T_FETCH = 4'b0001;
  localparam logic [3:0] T_READ  = 4'b0010;
  localparam logic [3:0] T_WRITE = 4'b0100;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [4*NUM_PE-1:0]    pe_type;
  logic [AW*NUM_PE-1:0]   pe_addr;
  logic [DW*NUM_PE-1:0]   pe_data;
  logic [NUM_PE-1:0]      pe_valid;
  logic [NUM_PE-1:0]      pe_ready;
  logic [DW-1:0]          pe_rsp_data;
  logic [NUM_PE-1:0]      pe_rsp_valid;
  logic [NUM_PE-1:0]      pe_rsp_ready;
  logic [3:0]             req_type;
  logic [AW-1:0]          req_addr;
  logic [DW-1:0]          req_data;
  logic                   type_valid;
  logic                   type_ready;
  logic [DW-1:0]          rsp_data;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic                   err_illegal;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fiber_pe_arbiter #(
    .NUM_PE     (NUM_PE),
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .RSP_DEPTH  (DEPTH)
  ) dut (
    .i_clk             (clk),
    .i_reset           (rst),
    .i_pe_request_type (pe_type),
    .i_pe_addr         (pe_addr),
    .i_pe_data         (pe_data),
    .i_pe_valid        (pe_valid),
    .o_pe_ready        (pe_ready),
    .o_pe_rsp_data     (pe_rsp_data),
    .o_pe_rsp_valid    (pe_rsp_valid),
    .i_pe_rsp_ready    (pe_rsp_ready),
    .o_request_type    (req_type),
    .o_addr            (req_addr),
    .o_data            (req_data),
    .o_type_valid      (type_valid),
    .i_type_ready      (type_ready),
    .i_rsp_data        (rsp_data),
    .i_rsp_valid       (rsp_valid),
    .o_rsp_ready       (rsp_ready),
    .o_err_illegal     (err_illegal)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    pe_type      = '0;
    pe_addr      = '0;
    pe_data      = '0;
    pe_valid     = '0;
    pe_rsp_ready = '1;
    type_ready   = 1'b1;
    rsp_data     = '0;
    rsp_valid    = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic set_req(input int k, input logic [3:0] t,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    pe_type[4*k +: 4]   = t;
    pe_addr[AW*k +: AW] = a;
    pe_data[DW*k +: DW] = d;
    pe_valid[k]         = 1'b1;
  endtask

  // Issue one legal request from PE k with i_type_ready high and return to
  // IDLE; a grant that never arrives is a failed comparison.
  task automatic do_req(input int k, input logic [3:0] t,
                        input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit got = 0;
    set_req(k, t, a, d);
    #1;
    for (int c = 0; c < 20; c++) begin
      if (pe_ready[k]) begin
        got = 1;
        break;
      end
      step();
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL do_req_grant pe%0d: no o_pe_ready within 20 cycles", k);
    end
    step();
    pe_valid[k] = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    rsp_valid = 1'b1;
    step();
    checks++;
    if ({pe_ready, type_valid, err_illegal, pe_rsp_valid, rsp_ready} !== '0) begin
      errors++;
      $display("FAIL reset_ctrl: ready=%b tv=%b err=%b rspv=%b rspr=%b want all 0",
               pe_ready, type_valid, err_illegal, pe_rsp_valid, rsp_ready);
    end
    checks++;
    if ({req_type, req_addr, req_data} !== '0) begin
      errors++;
      $display("FAIL reset_data: type=%b addr=%h data=%h want 0",
               req_type, req_addr, req_data);
    end
    rsp_valid = 1'b0;
    rst = 1'b0;
    step();
  endtask

  task automatic test_single_write();
    do_reset();
    set_req(2, T_WRITE, 64'h0000_0000_FFFF_FFFF, 16'hFFFF);
    #1;
    checks++;
    if (pe_ready !== 4'b0100) begin
      errors++;
      $display("FAIL wr_grant: got %b want 0100", pe_ready);
    end
    step();
    pe_valid[2] = 1'b0;
    rsp_valid = 1'b1;
    #1;
    checks++;
    if (pe_ready !== 4'b0000) begin
      errors++;
      $display("FAIL wr_ready_pulse: got %b want 0000", pe_ready);
    end
    checks++;
    if ({type_valid, req_type, req_addr, req_data} !==
        {1'b1, T_WRITE, 64'h0000_0000_FFFF_FFFF, 16'hFFFF}) begin
      errors++;
      $display("FAIL wr_issue: tv=%b type=%b addr=%h data=%h want 1 0100 00000000ffffffff ffff",
               type_valid, req_type, req_addr, req_data);
    end
    checks++;
    if ({rsp_ready, pe_rsp_valid} !== 5'b0) begin
      errors++;
      $display("FAIL wr_fifo_empty: rsp_ready=%b rspv=%b want 0 0000", rsp_ready, pe_rsp_valid);
    end
    rsp_valid = 1'b0;
    step();
    checks++;
    if (type_valid !== 1'b0) begin
      errors++;
      $display("FAIL wr_done: tv=%b want 0", type_valid);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int k = 0; k < NUM_PE; k++) set_req(k, T_WRITE, AW'(k + 16), DW'(k + 32));
    #1;
    for (int n = 0; n < 8; n++) begin
      checks++;
      if (pe_ready !== 4'(1 << (n % 4))) begin
        errors++;
        $display("FAIL rr_grant%0d: got %b want %b", n, pe_ready, 4'(1 << (n % 4)));
      end
      step();
      checks++;
      if ({type_valid, req_addr, pe_ready} !== {1'b1, AW'((n % 4) + 16), 4'b0000}) begin
        errors++;
        $display("FAIL rr_issue%0d: tv=%b addr=%h ready=%b want 1 %h 0000",
                 n, type_valid, req_addr, pe_ready, AW'((n % 4) + 16));
      end
      step();
    end
    pe_valid = '0;
    step();
  endtask

  task automatic test_read_rsp();
    do_reset();
    do_req(1, T_READ, 64'h100, 16'h0);
    do_req(3, T_READ, 64'h300, 16'h0);
    rsp_valid = 1'b1;
    rsp_data  = 16'hAAAA;
    #1;
    checks++;
    if ({pe_rsp_valid, pe_rsp_data, rsp_ready} !== {4'b0010, 16'hAAAA, 1'b1}) begin
      errors++;
      $display("FAIL rsp_first: v=%b d=%h r=%b want 0010 aaaa 1", pe_rsp_valid, pe_rsp_data, rsp_ready);
    end
    step();
    rsp_data = 16'h5555;
    #1;
    checks++;
    if ({pe_rsp_valid, pe_rsp_data, rsp_ready} !== {4'b1000, 16'h5555, 1'b1}) begin
      errors++;
      $display("FAIL rsp_second: v=%b d=%h r=%b want 1000 5555 1", pe_rsp_valid, pe_rsp_data, rsp_ready);
    end
    step();
    checks++;
    if ({pe_rsp_valid, rsp_ready} !== 5'b0) begin
      errors++;
      $display("FAIL rsp_empty_stall: v=%b r=%b want 0000 0", pe_rsp_valid, rsp_ready);
    end
    rsp_valid = 1'b0;
    step();
  endtask

  task automatic test_backpressure();
    do_reset();
    type_ready = 1'b0;
    set_req(0, T_WRITE, 64'h1111, 16'h2222);
    #1;
    checks++;
    if (pe_ready !== 4'b0001) begin
      errors++;
      $display("FAIL bp_grant: got %b want 0001", pe_ready);
    end
    step();
    pe_valid[0] = 1'b0;
    set_req(1, T_WRITE, 64'h3333, 16'h4444);
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if ({type_valid, req_type, req_addr, req_data, pe_ready} !==
          {1'b1, T_WRITE, 64'h1111, 16'h2222, 4'b0000}) begin
        errors++;
        $display("FAIL bp_hold%0d: tv=%b type=%b addr=%h data=%h ready=%b want 1 0100 1111 2222 0000",
                 c, type_valid, req_type, req_addr, req_data, pe_ready);
      end
      step();
    end
    type_ready = 1'b1;
    step();
    checks++;
    if ({type_valid, pe_ready} !== {1'b0, 4'b0010}) begin
      errors++;
      $display("FAIL bp_release: tv=%b ready=%b want 0 0010", type_valid, pe_ready);
    end
    step();
    pe_valid = '0;
    step();
    // Response-side backpressure from PE 1.
    do_req(1, T_READ, 64'h10, 16'h0);
    pe_rsp_ready = 4'b1101;
    rsp_valid    = 1'b1;
    rsp_data     = 16'hC0DE;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if ({rsp_ready, pe_rsp_valid} !== {1'b0, 4'b0010}) begin
        errors++;
        $display("FAIL rsp_bp%0d: r=%b v=%b want 0 0010", c, rsp_ready, pe_rsp_valid);
      end
      step();
    end
    pe_rsp_ready = '1;
    #1;
    checks++;
    if (rsp_ready !== 1'b1) begin
      errors++;
      $display("FAIL rsp_bp_release: r=%b want 1", rsp_ready);
    end
    step();
    checks++;
    if ({rsp_ready, pe_rsp_valid} !== 5'b0) begin
      errors++;
      $display("FAIL rsp_bp_popped: r=%b v=%b want 0 0000", rsp_ready, pe_rsp_valid);
    end
    rsp_valid = 1'b0;
  endtask

  task automatic test_fifo_full();
    do_reset();
    for (int n = 0; n < DEPTH; n++) do_req(0, T_READ, AW'(n), 16'h0);
    // rr_ptr is now 1: PE 0 READ is blocked, PE 2 WRITE goes through.
    set_req(0, T_READ, 64'h99, 16'h0);
    set_req(2, T_WRITE, 64'h22, 16'h0);
    #1;
    checks++;
    if (pe_ready !== 4'b0100) begin
      errors++;
      $display("FAIL full_write_grant: got %b want 0100", pe_ready);
    end
    step();
    pe_valid[2] = 1'b0;
    step();
    checks++;
    if (pe_ready !== 4'b0000) begin
      errors++;
      $display("FAIL full_read_blocked: got %b want 0000", pe_ready);
    end
    rsp_valid = 1'b1;
    rsp_data  = 16'h1234;
    #1;
    checks++;
    if ({rsp_ready, pe_rsp_valid, pe_ready} !== {1'b1, 4'b0001, 4'b0000}) begin
      errors++;
      $display("FAIL full_pop_cycle: r=%b v=%b ready=%b want 1 0001 0000",
               rsp_ready, pe_rsp_valid, pe_ready);
    end
    step();
    rsp_valid = 1'b0;
    #1;
    checks++;
    if (pe_ready !== 4'b0001) begin
      errors++;
      $display("FAIL full_after_pop: got %b want 0001", pe_ready);
    end
    step();
    pe_valid = '0;
    step();
  endtask

  task automatic test_illegal();
    do_reset();
    set_req(1, 4'b0011, 64'h77, 16'h77);
    #1;
    checks++;
    if ({pe_ready, err_illegal} !== {4'b0010, 1'b1}) begin
      errors++;
      $display("FAIL ill_pulse: ready=%b err=%b want 0010 1", pe_ready, err_illegal);
    end
    step();
    pe_valid[1] = 1'b0;
    #1;
    checks++;
    if ({type_valid, err_illegal, rsp_ready} !== 3'b000) begin
      errors++;
      $display("FAIL ill_dropped: tv=%b err=%b rspr=%b want 0 0 0", type_valid, err_illegal, rsp_ready);
    end
    set_req(1, T_FETCH, 64'h1, 16'h0);
    set_req(2, T_WRITE, 64'h2, 16'h0);
    #1;
    checks++;
    if (pe_ready !== 4'b0100) begin
      errors++;
      $display("FAIL ill_rr_advance: got %b want 0100", pe_ready);
    end
    step();
    pe_valid = '0;
    step();
  endtask

  task automatic test_reset_in_issue();
    do_reset();
    do_req(1, T_READ, 64'h5, 16'h0);
    type_ready = 1'b0;
    set_req(0, T_WRITE, 64'hDEAD, 16'hBEEF);
    #1;
    checks++;
    if (pe_ready !== 4'b0001) begin
      errors++;
      $display("FAIL rst_issue_grant: got %b want 0001", pe_ready);
    end
    step();
    pe_valid  = '0;
    rsp_valid = 1'b1;
    #1;
    checks++;
    if ({type_valid, req_addr, rsp_ready} !== {1'b1, 64'hDEAD, 1'b1}) begin
      errors++;
      $display("FAIL rst_issue_pre: tv=%b addr=%h r=%b want 1 dead 1", type_valid, req_addr, rsp_ready);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({pe_ready, type_valid, err_illegal, pe_rsp_valid, rsp_ready,
         req_type, req_addr, req_data} !== '0) begin
      errors++;
      $display("FAIL rst_issue_async: ready=%b tv=%b err=%b v=%b r=%b type=%b addr=%h data=%h want all 0",
               pe_ready, type_valid, err_illegal, pe_rsp_valid, rsp_ready, req_type, req_addr, req_data);
    end
    step();
    rst = 1'b0;
    step();
    checks++;
    if ({type_valid, rsp_ready} !== 2'b00) begin
      errors++;
      $display("FAIL rst_issue_after: tv=%b r=%b want 0 0", type_valid, rsp_ready);
    end
    clear_inputs();
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_single_write();
    test_round_robin();
    test_read_rsp();
    test_backpressure();
    test_fifo_full();
    test_illegal();
    test_reset_in_issue();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
